// File: rtl/seg7_pkg.sv
// Shared glyph patterns (active-low, gfedcba), banner/state encodings and
// pending-queue helpers for the seven-segment banner scheduler.
package seg7_pkg;

  localparam logic [6:0] G_0     = 7'h40;
  localparam logic [6:0] G_1     = 7'h79;
  localparam logic [6:0] G_2     = 7'h24;
  localparam logic [6:0] G_3     = 7'h30;
  localparam logic [6:0] G_4     = 7'h19;
  localparam logic [6:0] G_5     = 7'h12;
  localparam logic [6:0] G_6     = 7'h02;
  localparam logic [6:0] G_7     = 7'h78;
  localparam logic [6:0] G_8     = 7'h00;
  localparam logic [6:0] G_9     = 7'h10;
  localparam logic [6:0] G_A     = 7'h08;
  localparam logic [6:0] G_B     = 7'h03;
  localparam logic [6:0] G_C     = 7'h46;
  localparam logic [6:0] G_D     = 7'h21;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_F     = 7'h0E;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_U     = 7'h41;
  localparam logic [6:0] G_R     = 7'h2F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    BN_NONE = 2'd0,
    BN_LOAD = 2'd1,
    BN_SAVE = 2'd2,
    BN_ERR  = 2'd3
  } banner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Pending vector layout: bit0 LOAd, bit1 SAUE, bit2 Err (highest priority).
  function automatic banner_t pick_banner(input logic [2:0] pend);
    banner_t b;
    if (pend[2]) begin
      b = BN_ERR;
    end else if (pend[1]) begin
      b = BN_SAVE;
    end else if (pend[0]) begin
      b = BN_LOAD;
    end else begin
      b = BN_NONE;
    end
    return b;
  endfunction

  function automatic logic [2:0] banner_mask(input banner_t b);
    logic [2:0] m;
    case (b)
      BN_LOAD: m = 3'b001;
      BN_SAVE: m = 3'b010;
      BN_ERR:  m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational nibble to active-low seven-segment pattern (0-9, A b C d E F).
module seg7_hex_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    case (nibble)
      4'h0:    pattern = G_0;
      4'h1:    pattern = G_1;
      4'h2:    pattern = G_2;
      4'h3:    pattern = G_3;
      4'h4:    pattern = G_4;
      4'h5:    pattern = G_5;
      4'h6:    pattern = G_6;
      4'h7:    pattern = G_7;
      4'h8:    pattern = G_8;
      4'h9:    pattern = G_9;
      4'hA:    pattern = G_A;
      4'hB:    pattern = G_B;
      4'hC:    pattern = G_C;
      4'hD:    pattern = G_D;
      4'hE:    pattern = G_E;
      4'hF:    pattern = G_F;
      default: pattern = G_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_banner_scheduler.sv
// Shares the 8-digit display between the live hex view and the timed
// LOAd / SAUE / Err banners (priority queued, Err pre-empts and blinks).
module seven_seg_banner_scheduler
  import seg7_pkg::*;
#(
  parameter int HOLD_CYCLES  = 10_000_000,
  parameter int BLINK_CYCLES = 5_000_000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iLive,
  input  logic [7:0]  iLiveEn,
  input  logic        iLoadReq,
  input  logic        iSaveReq,
  input  logic        iErrReq,
  input  logic        iCancel,
  output logic [6:0]  o_seven_7,
  output logic [6:0]  o_seven_6,
  output logic [6:0]  o_seven_5,
  output logic [6:0]  o_seven_4,
  output logic [6:0]  o_seven_3,
  output logic [6:0]  o_seven_2,
  output logic [6:0]  o_seven_1,
  output logic [6:0]  o_seven_0,
  output logic        o_busy,
  output logic [1:0]  o_banner
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = $clog2(2 * BLINK_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_CYCLES);

  state_t        state_r, state_n;
  banner_t       banner_r, banner_n;
  logic [HW-1:0] hold_cnt_r, hold_n;
  logic [BW-1:0] blink_cnt_r, blink_n, blink_adv_s;
  logic [2:0]    pend_r, pend_n;
  logic [2:0]    req_q_r, req_s, ev_s;
  logic [2:0]    set_s, take_s, cur_mask_s;

  logic [6:0]    glyph_s [8];
  logic [6:0]    live_s  [8];
  logic [6:0]    seg_n   [8];
  logic [6:0]    seven_r [8];
  logic          busy_n, busy_r;
  banner_t       bnout_n, bnout_r;

  assign req_s       = {iErrReq, iSaveReq, iLoadReq};
  assign ev_s        = req_s & ~req_q_r;
  assign cur_mask_s  = banner_mask(banner_r);
  assign blink_adv_s = (blink_cnt_r == BLINK_LAST) ? '0 : blink_cnt_r + BW'(1);

  for (genvar k = 0; k < 8; k++) begin : g_live
    seg7_hex_glyph u_glyph (
      .nibble  (iLive[4*k +: 4]),
      .pattern (glyph_s[k])
    );
    assign live_s[k] = iLiveEn[k] ? glyph_s[k] : G_DASH;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r     <= ST_IDLE;
      banner_r    <= BN_NONE;
      hold_cnt_r  <= '0;
      blink_cnt_r <= '0;
      pend_r      <= 3'b000;
      req_q_r     <= 3'b000;
    end else begin
      state_r     <= state_n;
      banner_r    <= banner_n;
      hold_cnt_r  <= hold_n;
      blink_cnt_r <= blink_n;
      pend_r      <= pend_n;
      req_q_r     <= req_s;
    end
  end

  // Cancel beats everything; in SHOW, Err and on-screen events never queue.
  always_comb begin
    state_n  = state_r;
    banner_n = banner_r;
    hold_n   = hold_cnt_r;
    blink_n  = blink_cnt_r;
    set_s    = ev_s;
    take_s   = 3'b000;
    pend_n   = pend_r;
    if (iCancel) begin
      state_n  = ST_IDLE;
      banner_n = BN_NONE;
      hold_n   = '0;
      blink_n  = '0;
      pend_n   = 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pend_r != 3'b000) begin
            banner_n = pick_banner(pend_r);
            take_s   = banner_mask(banner_n);
            state_n  = ST_SHOW;
            hold_n   = '0;
            blink_n  = '0;
          end else begin
            banner_n = BN_NONE;
          end
        end
        ST_SHOW: begin
          set_s = ev_s & ~cur_mask_s & 3'b011;
          if (ev_s[2] && (banner_r != BN_ERR)) begin
            banner_n = BN_ERR;
            hold_n   = '0;
            blink_n  = '0;
          end else if ((ev_s & cur_mask_s) != 3'b000) begin
            hold_n  = '0;
            blink_n = (banner_r == BN_ERR) ? '0 : blink_cnt_r;
          end else if (hold_cnt_r == HOLD_LAST) begin
            hold_n  = '0;
            blink_n = '0;
            if (pend_r != 3'b000) begin
              banner_n = pick_banner(pend_r);
              take_s   = banner_mask(banner_n);
            end else begin
              state_n  = ST_IDLE;
              banner_n = BN_NONE;
            end
          end else begin
            hold_n  = hold_cnt_r + HW'(1);
            blink_n = (banner_r == BN_ERR) ? blink_adv_s : '0;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          banner_n = BN_NONE;
          hold_n   = '0;
          blink_n  = '0;
        end
      endcase
      pend_n = (pend_r | set_s) & ~take_s;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      seg_n[k] = live_s[k];
    end
    busy_n  = 1'b0;
    bnout_n = BN_NONE;
    if (state_r == ST_SHOW) begin
      busy_n  = 1'b1;
      bnout_n = banner_r;
      case (banner_r)
        BN_LOAD: {seg_n[3], seg_n[2], seg_n[1], seg_n[0]} = {G_L, G_O, G_A, G_D};
        BN_SAVE: {seg_n[3], seg_n[2], seg_n[1], seg_n[0]} = {G_S, G_A, G_U, G_E};
        BN_ERR: begin
          if (blink_cnt_r < BLINK_ON) begin
            {seg_n[3], seg_n[2], seg_n[1], seg_n[0]} = {G_E, G_R, G_R, G_BLANK};
          end else begin
            {seg_n[3], seg_n[2], seg_n[1], seg_n[0]} = {4{G_BLANK}};
          end
        end
        default: begin
          busy_n  = 1'b0;
          bnout_n = BN_NONE;
        end
      endcase
    end else begin
      busy_n  = 1'b0;
      bnout_n = BN_NONE;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < 8; k++) begin
        seven_r[k] <= G_BLANK;
      end
      busy_r  <= 1'b0;
      bnout_r <= BN_NONE;
    end else begin
      for (int k = 0; k < 8; k++) begin
        seven_r[k] <= seg_n[k];
      end
      busy_r  <= busy_n;
      bnout_r <= bnout_n;
    end
  end

  assign o_seven_7 = seven_r[7];
  assign o_seven_6 = seven_r[6];
  assign o_seven_5 = seven_r[5];
  assign o_seven_4 = seven_r[4];
  assign o_seven_3 = seven_r[3];
  assign o_seven_2 = seven_r[2];
  assign o_seven_1 = seven_r[1];
  assign o_seven_0 = seven_r[0];
  assign o_busy    = busy_r;
  assign o_banner  = bnout_r;

endmodule
